// File: rtl/prm_seq_pkg.sv
// Shared types and defaults for the parameter-load sequencer (prm_seq).
package prm_seq_pkg;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'd0,
        MODE_BWD  = 2'd1,
        MODE_BIAS = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NCH_DEF = 16;
    localparam int AW_DEF  = 10;

endpackage

// File: rtl/prm_seq_loop.sv
// loop_cnt: one level of the sequencer's nested loop; counts 0..fin and wraps to 0.
module loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] fin,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         wrap
);

    assign last = (cnt == fin);
    assign wrap = en & last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/prm_seq.sv
// prm_seq: streams parameter words into per-channel RAM banks as ki/oc/ic nested loops.
// Optional s_last/err framing check is enabled by defining PRM_SEQ_LAST_CHK_EN.
module prm_seq
    import prm_seq_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    localparam int VW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [1:0]     mode,
    input  logic [VW-1:0]  id,
    input  logic [VW-1:0]  od,
    input  logic [AW-1:0]  fs,
    input  logic [AW-1:0]  ks,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [NCH-1:0] prm_we,
    output logic [VW-1:0]  prm_v,
    output logic [AW-1:0]  prm_a,
    output logic           busy,
    output logic           done
`ifdef PRM_SEQ_LAST_CHK_EN
    ,
    input  logic           s_last,
    output logic           err
`endif
);

    localparam int AVW = AW + VW;

    state_t        state;
    logic [1:0]    mode_s;
    logic [VW-1:0] id_s, od_s;
    logic [AW-1:0] fs_s, ks_s;

    logic          run, beat, clr, bwd;
    logic [VW-1:0] ice;
    logic [AW-1:0] kie;
    logic [AW-1:0] ki;
    logic [VW-1:0] oc, ic;
    logic          ki_last, oc_last, ic_last;
    logic          ki_wrap, oc_wrap;
    logic          fin_beat;
    logic [AVW-1:0] bw_addr;

    assign run  = (state == RUN);
    assign beat = s_valid & run;
    assign clr  = ~run | abort;
    assign bwd  = (mode_s == MODE_BWD);
    assign ice  = bwd ? id_s : '0;
    assign kie  = bwd ? ks_s : ((mode_s == MODE_FWD) ? fs_s : '0);

    loop_cnt #(.W(AW)) u_ki (
        .clk(clk), .rst(rst), .clr(clr), .en(beat), .fin(kie),
        .cnt(ki), .last(ki_last), .wrap(ki_wrap)
    );
    loop_cnt #(.W(VW)) u_oc (
        .clk(clk), .rst(rst), .clr(clr), .en(ki_wrap), .fin(od_s),
        .cnt(oc), .last(oc_last), .wrap(oc_wrap)
    );
    loop_cnt #(.W(VW)) u_ic (
        .clk(clk), .rst(rst), .clr(clr), .en(oc_wrap), .fin(ice),
        .cnt(ic), .last(ic_last), .wrap()
    );

    assign fin_beat = beat & ki_last & oc_last & ic_last;

    // Transposed layout: each input channel owns a block of ks+1 addresses, walked backwards.
    assign bw_addr = AVW'(ic) * (AVW'(ks_s) + AVW'(1)) + AVW'(ks_s) - AVW'(ki);
    assign prm_a   = bwd ? bw_addr[AW-1:0] : ki;
    assign prm_v   = oc;

    always_comb begin
        prm_we = '0;
        for (int i = 0; i < NCH; i++) begin
            if (beat && (oc == VW'(i))) prm_we[i] = 1'b1;
        end
    end

    assign s_ready = run;
    assign busy    = run | (state == DONE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_s <= 2'd0;
            id_s   <= '0;
            od_s   <= '0;
            fs_s   <= '0;
            ks_s   <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    mode_s <= mode;
                    id_s   <= id;
                    od_s   <= od;
                    fs_s   <= fs;
                    ks_s   <= ks;
                end
                RUN:     if (fin_beat) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRM_SEQ_LAST_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start && !abort) begin
            err <= 1'b0;
        end else if (beat && (s_last != fin_beat)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prm_seq.sv
// Scoreboard bench for prm_seq: driver queues expected beats, monitor compares on each handshake.
module tb_prm_seq;

    localparam int NCH = 16;
    localparam int AW  = 10;
    localparam int VW  = 4;

    logic           clk = 1'b0;
    logic           rst, start, abort, s_valid;
    logic [1:0]     mode;
    logic [VW-1:0]  id, od;
    logic [AW-1:0]  fs, ks;
    logic           s_ready, busy, done;
    logic [NCH-1:0] prm_we;
    logic [VW-1:0]  prm_v;
    logic [AW-1:0]  prm_a;
`ifdef PRM_SEQ_LAST_CHK_EN
    logic           s_last, err;
`endif

    always #5 clk = ~clk;

    prm_seq #(.NCH(NCH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .id(id), .od(od), .fs(fs), .ks(ks), .s_valid(s_valid), .s_ready(s_ready),
        .prm_we(prm_we), .prm_v(prm_v), .prm_a(prm_a), .busy(busy), .done(done)
`ifdef PRM_SEQ_LAST_CHK_EN
        , .s_last(s_last), .err(err)
`endif
    );

    typedef struct packed {
        logic [NCH-1:0] we;
        logic [VW-1:0]  v;
        logic [AW-1:0]  a;
        logic           fin;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected beats in loop order: ki innermost, then oc, then ic.
    task automatic gen(input int md, input int id_, input int od_, input int fs_, input int ks_,
                       input int limit, output int total);
        int   ice, kie, k;
        exp_t e;
        ice   = (md == 1) ? id_ : 0;
        kie   = (md == 1) ? ks_ : ((md == 0) ? fs_ : 0);
        total = (ice + 1) * (od_ + 1) * (kie + 1);
        k     = 0;
        for (int ic = 0; ic <= ice; ic++)
            for (int oc = 0; oc <= od_; oc++)
                for (int ki = 0; ki <= kie; ki++) begin
                    k++;
                    if (k <= limit) begin
                        e.we  = NCH'(1) << oc;
                        e.v   = VW'(oc);
                        e.a   = (md == 1) ? AW'(ic * (ks_ + 1) + ks_ - ki) : AW'(ki);
                        e.fin = (k == total);
                        sb.push_back(e);
                    end
                end
    endtask

    task automatic run_job(input int md, input int id_, input int od_, input int fs_, input int ks_,
                           input logic [3:0] pat, input int plen, input int abort_at, input int last_at);
        int total, nb, n, k, lt;
        gen(md, id_, od_, fs_, ks_, (abort_at > 0) ? abort_at : 32'h7fff_ffff, total);
        nb = (abort_at > 0) ? abort_at : total;
        lt = (last_at > 0) ? last_at : total;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = md[1:0];
        id    = VW'(id_);
        od    = VW'(od_);
        fs    = AW'(fs_);
        ks    = AW'(ks_);
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'd3;
        id    = '1;
        od    = '1;
        fs    = '1;
        ks    = '1;
        chk("s_ready_after_start", s_ready, 1);
        chk("busy_in_run", busy, 1);
        n = 0;
        k = 0;
        while (n < nb) begin
            s_valid = pat[k % plen];
            k++;
            abort = s_valid && (n + 1 == abort_at);
`ifdef PRM_SEQ_LAST_CHK_EN
            s_last = s_valid && (n + 1 == lt);
`endif
            if (s_valid) n++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        abort   = 1'b0;
`ifdef PRM_SEQ_LAST_CHK_EN
        s_last  = 1'b0;
`endif
        if (abort_at > 0) begin
            chk("abort_s_ready", s_ready, 0);
            chk("abort_busy", busy, 0);
            repeat (3) @(posedge clk);
            #1;
        end else begin
            chk("busy_in_done", busy, 1);
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin : monitor
        logic exp_done;
        exp_t e;
        exp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_done = 1'b0;
                continue;
            end
            chk("done", done, exp_done);
            if (exp_done) chk("s_ready_in_done", s_ready, 0);
            exp_done = 1'b0;
            if (s_valid && s_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: prm_we %0h prm_a %0d with nothing queued at %0t",
                             prm_we, prm_a, $time);
                end else begin
                    e = sb.pop_front();
                    chk("prm_we", prm_we, e.we);
                    chk("prm_v", prm_v, e.v);
                    chk("prm_a", prm_a, e.a);
                    exp_done = e.fin && !abort;
                end
            end else begin
                chk("we_without_beat", prm_we, 0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int tot;
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        mode = 2'd0; id = '0; od = '0; fs = '0; ks = '0;
`ifdef PRM_SEQ_LAST_CHK_EN
        s_last = 1'b0;
`endif
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_prm_we", prm_we, 0);
        chk("rst_prm_v", prm_v, 0);
        chk("rst_prm_a", prm_a, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // start together with abort in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_ready", s_ready, 0);

        run_job(0, 0, 3, 24, 0, 4'b1111, 1, 0, 0);   // forward, 100 beats
        run_job(1, 1, 1, 0, 8, 4'b1111, 1, 0, 0);    // backprop, 36 beats
        run_job(2, 0, 9, 0, 0, 4'b1111, 1, 0, 0);    // bias, 10 beats
        run_job(3, 0, 2, 5, 5, 4'b1111, 1, 0, 0);    // reserved mode behaves as bias
        run_job(0, 0, 3, 24, 0, 4'b0001, 3, 0, 0);   // backpressure 1,0,0
        run_job(0, 0, 3, 24, 0, 4'b1111, 1, 37, 0);  // abort at beat 37
        run_job(0, 0, 3, 24, 0, 4'b1111, 1, 0, 0);   // restart after abort

        // asynchronous reset in the middle of a bias job
        gen(2, 0, 5, 0, 0, 2, tot);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd2; od = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_prm_v", prm_v, 2);
        #1 rst = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 0);
        chk("arst_prm_we", prm_we, 0);
        chk("arst_prm_v", prm_v, 0);
        chk("arst_prm_a", prm_a, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        s_valid = 1'b0;
        chk("arst_sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        rst = 1'b1;

`ifdef PRM_SEQ_LAST_CHK_EN
        run_job(0, 0, 3, 24, 0, 4'b1111, 1, 0, 99);  // s_last one beat early
        chk("err_set", err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        run_job(2, 0, 9, 0, 0, 4'b1111, 1, 0, 0);
        chk("err_cleared", err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prm_seq.md
# prm_seq

Parametrised parameter-load sequencer for the MNIST accelerator. It is the successor to the weight/bias write loop inside the batch controller. It accepts a stream of parameter words under valid/ready handshake and generates channel-enable and kernel-address strobes for forward-weight, transposed backprop-weight and bias writes. It sits between the host DMA stream and the per-channel parameter RAMs. It adds backpressure, a start/done protocol, abort, and a parametrised channel count.

## Interface
- `NCH`, 16: number of output channels (parameter RAM banks); `VW = $clog2(NCH)`.
- `AW`, 10: kernel address width.
- `clk` in 1: clock; all flops rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; highest priority after reset.
- `mode` in 2: 0 = forward weight, 1 = backprop weight, 2 = bias, 3 = reserved (treated as bias).
- `id` in VW: last input-channel index (count − 1).
- `od` in VW: last output-channel index (count − 1).
- `fs` in AW: last forward kernel index.
- `ks` in AW: last backprop kernel index.
- `s_valid` in 1, `s_ready` out 1: parameter-word handshake; beat = `s_valid & s_ready`.
- `prm_we` out NCH: one-hot bank write enable, asserted only on a beat.
- `prm_v` out VW: current output-channel index (oc).
- `prm_a` out AW: current kernel address.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse after the final beat.

## Operation
- States: IDLE → RUN on `start`; RUN → DONE on the final beat; DONE → IDLE unconditionally after 1 cycle. `abort` forces IDLE from any state with counters cleared, and no `done` is produced.
- On `start`, latch `mode`, `id`, `od`, `fs`, `ks` into shadow registers. Inputs may change afterwards without effect.
- Loop limits:
  - ice = (mode==1) ? id : 0.
  - kie = mode 1 → ks; mode 0 → fs; mode 2/3 → 0.
  - ocl = od.
- Loop nesting: ki innermost (0..kie), then oc (0..ocl), then ic (0..ice). All three start at 0 on entry to RUN. Each beat advances ki. The ki wrap advances oc, and the oc wrap advances ic.
- Final beat: ki==kie & oc==ocl & ic==ice. Total beats = (ice+1)(ocl+1)(kie+1).
- `prm_a`:
  - mode 1: ic*(ks+1) + ks − ki, computed at AW+VW bits and truncated to AW.
  - Otherwise: ki.
- `prm_we` = beat ? (1<<oc) : 0. `prm_v` = oc. If `od` ≥ NCH, the oc index is taken modulo 2^VW and `prm_we` is zero for indices ≥ NCH.
- `s_ready` = (state==RUN). It is never asserted in IDLE or DONE, so stray words are held back.
- Simultaneous `start` and `abort` in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset values: `s_ready`=0, `prm_we`=0, `prm_v`=0, `prm_a`=0, `busy`=0, `done`=0, state=IDLE.
- `start` to `s_ready` high: 1 cycle.
- `prm_we`, `prm_v` and `prm_a` are combinational from the registered counters and the handshake. They are valid in the same cycle as the beat (zero latency), and the counters update at that clock edge.
- With `s_valid` low, the counters hold and `prm_we`=0.
- Final beat to `done`: `done` is high in the following cycle (DONE state) and `s_ready` is 0 in that cycle.
- Back-to-back jobs: `start` can be accepted in the cycle after DONE. The minimum gap between the final beat of one job and the first beat of the next is 3 cycles.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronously) and the job is lost.

## Configuration
- Macro `PRM_SEQ_LAST_CHK_EN`.
- Defined: adds input `s_last` (1) and output `err` (1, reset 0). `err` is set when, on a beat, `s_last` differs from the final-beat condition. It is sticky until the next accepted `start` or reset. Sequencing is unaffected.
- Undefined: neither port exists, and sequencing is identical.

## Structure
- Package `prm_seq_pkg`: `mode_t` enum (MODE_FWD, MODE_BWD, MODE_BIAS), `state_t` enum (IDLE, RUN, DONE), default NCH/AW localparams.
- Sub-module `loop_cnt`: parametrised width W, inputs clr/en/fin, outputs cnt/last (cnt==fin) and wrap (en & last), wrap-to-0. Instantiated three times (ki, oc, ic) inside `prm_seq`.

## Test plan
- Forward weight: mode 0, od=3, fs=24, `s_valid` held high → 100 beats. `prm_a` runs 0..24 per channel and `prm_we` goes 0x1, 0x2, 0x4, 0x8. `done` is high one cycle after beat 100.
- Backprop: mode 1, id=1, od=1, ks=8 → 36 beats. The first address sequence is 8..0 (ic=0); after both oc values it is 17..9 (ic=1).
- Bias: mode 2, od=9 → 10 beats. `prm_a`=0 throughout and `prm_we` walks bits 0..9.
- Backpressure: in mode 0 with `s_valid` toggling 1,0,0,1,… → counters and `prm_we` stall on the low cycles, and the address sequence matches the no-stall run.
- Abort: `abort` at beat 37 of the forward case → the block is in IDLE next cycle, `s_ready`=0 and `done` never pulses. A following `start` restarts from address 0, channel 0.
- With `PRM_SEQ_LAST_CHK_EN`: assert `s_last` on beat 99 of 100 → `err` is 1 from the next cycle and stays 1. The next `start` clears it.
